bist_controller: RTL and testbench

BIST_CONTROLLER -- requirements
Module: bist_controller

---
 rtl/bist_pkg.sv | 25 ++
 rtl/bist_timer.sv | 26 ++
 rtl/bist_controller.sv | 136 +++++++++++++
 tb/tb_bist_controller.sv | 228 ++++++++++++++++++++++
 4 files changed

// File: rtl/bist_pkg.sv
// rtl/bist_pkg.sv - shared state encoding and default constants for the BIST controller
package bist_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_SEED,
        S_RUN,
        S_DRAIN,
        S_WAIT_RDY,
        S_COMPARE,
        S_DONE
    } bist_state_t;

    localparam int          DEF_NUM_PATTERNS = 32;
    localparam int          DEF_DUT_LATENCY  = 1;
    localparam int          DEF_TIMEOUT      = 64;
    localparam logic [15:0] DEF_GOLDEN_SIG   = 16'h0000;

    // A phase lasting N cycles loads the down-counter with N-1; zero-length
    // phases still occupy one cycle, so 0 and 1 both load 0.
    function automatic logic [7:0] cycles_to_load(input int cycles);
        return (cycles <= 1) ? 8'd0 : 8'(cycles - 1);
    endfunction

endpackage

// File: rtl/bist_timer.sv
// rtl/bist_timer.sv - loadable saturating down-counter with zero flag
module bist_timer (
    input  logic       clk,
    input  logic       reset,
    input  logic       load,
    input  logic [7:0] load_value,
    input  logic       count_en,
    output logic       zero
);

    logic [7:0] count;

    // Load has priority; decrement stops at zero instead of wrapping.
    always_ff @(posedge clk) begin
        if (reset) begin
            count <= 8'd0;
        end else if (load) begin
            count <= load_value;
        end else if (count_en && count != 8'd0) begin
            count <= count - 8'd1;
        end
    end

    assign zero = (count == 8'd0);

endmodule

// File: rtl/bist_controller.sv
// rtl/bist_controller.sv - BIST sequencer: seed, run patterns, drain, await MISR, compare
module bist_controller
    import bist_pkg::*;
#(
    parameter int          NUM_PATTERNS = DEF_NUM_PATTERNS,
    parameter int          DUT_LATENCY  = DEF_DUT_LATENCY,
    parameter int          TIMEOUT      = DEF_TIMEOUT,
    parameter logic [15:0] GOLDEN_SIG   = DEF_GOLDEN_SIG
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    output logic        tpg_load,
    output logic        tpg_enable,
    output logic        misr_reset_n,
    input  logic        misr_ready,
    input  logic [15:0] signature,
    output logic        busy,
    output logic        done,
    output logic        pass,
    output logic        fail,
    output logic        timeout_err,
    output logic [15:0] result_sig,
    output logic [7:0]  pattern_cnt
);

    localparam logic [7:0] LAST_CNT = 8'(NUM_PATTERNS - 1);
    localparam logic [7:0] MAX_CNT  = 8'(NUM_PATTERNS);

    bist_state_t state, next_state;
    logic        timer_load;
    logic [7:0]  timer_value;
    logic        timer_en;
    logic        timer_zero;
    logic        launch;
    logic        timed_out;

    bist_timer u_timer (
        .clk        (clk),
        .reset      (reset),
        .load       (timer_load),
        .load_value (timer_value),
        .count_en   (timer_en),
        .zero       (timer_zero)
    );

    // start is only honoured when no run is in flight.
    assign launch    = (state == S_IDLE || state == S_DONE) && start;
    assign timed_out = (state == S_WAIT_RDY) && !misr_ready && timer_zero;

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= S_IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state decode; the shared timer is armed on entry to DRAIN and WAIT_RDY.
    always_comb begin
        next_state  = state;
        timer_load  = 1'b0;
        timer_value = 8'd0;
        timer_en    = 1'b0;
        case (state)
            S_IDLE:    if (start) next_state = S_SEED;
            S_SEED:    next_state = S_RUN;
            S_RUN: begin
                if (pattern_cnt >= LAST_CNT) begin
                    next_state  = S_DRAIN;
                    timer_load  = 1'b1;
                    timer_value = cycles_to_load(DUT_LATENCY);
                end
            end
            S_DRAIN: begin
                if (timer_zero) begin
                    next_state  = S_WAIT_RDY;
                    timer_load  = 1'b1;
                    timer_value = cycles_to_load(TIMEOUT);
                end else begin
                    timer_en = 1'b1;
                end
            end
            S_WAIT_RDY: begin
                if (misr_ready) begin
                    next_state = S_COMPARE;
                end else if (timer_zero) begin
                    next_state = S_DONE;
                end else begin
                    timer_en = 1'b1;
                end
            end
            S_COMPARE: next_state = S_DONE;
            S_DONE:    if (start) next_state = S_SEED;
            default:   next_state = S_IDLE;
        endcase
    end

    assign tpg_load     = (state == S_SEED);
    assign tpg_enable   = (state == S_RUN);
    assign misr_reset_n = !reset && (state != S_SEED);
    assign busy         = (state != S_IDLE) && (state != S_DONE);
    assign done         = (state == S_DONE);

    // Pattern counter and result flags; cleared as a new run launches so they read 0 in SEED.
    always_ff @(posedge clk) begin
        if (reset) begin
            pattern_cnt <= 8'd0;
            pass        <= 1'b0;
            fail        <= 1'b0;
            timeout_err <= 1'b0;
            result_sig  <= 16'd0;
        end else if (launch) begin
            pattern_cnt <= 8'd0;
            pass        <= 1'b0;
            fail        <= 1'b0;
            timeout_err <= 1'b0;
        end else begin
            if (state == S_RUN && pattern_cnt < MAX_CNT) begin
                pattern_cnt <= pattern_cnt + 8'd1;
            end
            if (state == S_COMPARE) begin
                result_sig <= signature;
                pass       <= (signature == GOLDEN_SIG);
                fail       <= (signature != GOLDEN_SIG);
            end
            if (timed_out) begin
                pass        <= 1'b0;
                fail        <= 1'b1;
                timeout_err <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_bist_controller.sv
// tb/tb_bist_controller.sv - self-checking bench for bist_controller
module tb_bist_controller;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start0 = 1'b0;
    logic        start1 = 1'b0;
    logic        misr_ready = 1'b0;
    logic [15:0] signature = 16'd0;
    logic        sel = 1'b0;

    logic        tpg_load0, tpg_enable0, misr_reset_n0, busy0, done0, pass0, fail0, timeout_err0;
    logic [15:0] result_sig0;
    logic [7:0]  pattern_cnt0;
    logic        tpg_load1, tpg_enable1, misr_reset_n1, busy1, done1, pass1, fail1, timeout_err1;
    logic [15:0] result_sig1;
    logic [7:0]  pattern_cnt1;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    bist_controller #(
        .NUM_PATTERNS(32), .DUT_LATENCY(1), .TIMEOUT(64), .GOLDEN_SIG(16'h1234)
    ) dut0 (
        .clk(clk), .reset(reset), .start(start0),
        .tpg_load(tpg_load0), .tpg_enable(tpg_enable0), .misr_reset_n(misr_reset_n0),
        .misr_ready(misr_ready), .signature(signature),
        .busy(busy0), .done(done0), .pass(pass0), .fail(fail0), .timeout_err(timeout_err0),
        .result_sig(result_sig0), .pattern_cnt(pattern_cnt0)
    );

    bist_controller #(
        .NUM_PATTERNS(2), .DUT_LATENCY(0), .TIMEOUT(5), .GOLDEN_SIG(16'hA5A5)
    ) dut1 (
        .clk(clk), .reset(reset), .start(start1),
        .tpg_load(tpg_load1), .tpg_enable(tpg_enable1), .misr_reset_n(misr_reset_n1),
        .misr_ready(misr_ready), .signature(signature),
        .busy(busy1), .done(done1), .pass(pass1), .fail(fail1), .timeout_err(timeout_err1),
        .result_sig(result_sig1), .pattern_cnt(pattern_cnt1)
    );

    wire        o_load = sel ? tpg_load1     : tpg_load0;
    wire        o_en   = sel ? tpg_enable1   : tpg_enable0;
    wire        o_mrn  = sel ? misr_reset_n1 : misr_reset_n0;
    wire        o_busy = sel ? busy1         : busy0;
    wire        o_done = sel ? done1         : done0;
    wire        o_pass = sel ? pass1         : pass0;
    wire        o_fail = sel ? fail1         : fail0;
    wire        o_to   = sel ? timeout_err1  : timeout_err0;
    wire [15:0] o_rsig = sel ? result_sig1   : result_sig0;
    wire [7:0]  o_cnt  = sel ? pattern_cnt1  : pattern_cnt0;

    typedef struct {
        bit          s;
        int          rdy_at;
        logic [15:0] sig;
        bit          hold;
        int          exp_done;
        bit          exp_pass;
        bit          exp_fail;
        bit          exp_to;
        logic [15:0] exp_rsig;
    } vec_t;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Parameters of the selected instance, as seen by the reference model.
    function automatic int p_n(input bit s);      return s ? 2 : 32;  endfunction
    function automatic int p_lat(input bit s);    return s ? 0 : 1;   endfunction
    function automatic int p_to(input bit s);     return s ? 5 : 64;  endfunction
    function automatic logic [15:0] p_gold(input bit s); return s ? 16'hA5A5 : 16'h1234; endfunction

    // Edge (counted from the edge that samples start) on which done first shows:
    // one SEED cycle, N run cycles, max(lat,1) drain cycles, then the wait window.
    function automatic int model_done(input bit s, input int r);
        int w;
        w = 1 + p_n(s) + ((p_lat(s) < 1) ? 1 : p_lat(s));
        if (r <= w + 1) return w + 2;
        if (r <= w + p_to(s)) return r + 1;
        return w + p_to(s);
    endfunction

    // misr_ready is high for every edge index >= rdy_at.
    task automatic do_run(input bit s, input int rdy_at, input logic [15:0] sig, input bit hold,
                          output int done_edge, output int n_en, output int n_load,
                          output int n_mrn, output int n_bad, output logic [7:0] snap);
        sel = s;
        signature = sig;
        misr_ready = (rdy_at <= 0);
        if (s) start1 = 1'b1; else start0 = 1'b1;
        done_edge = -1; n_en = 0; n_load = 0; n_mrn = 0; n_bad = 0; snap = 8'h00;
        for (int k = 0; k < 400; k++) begin
            tick();
            if (k == 0) begin
                snap = {o_load, o_mrn, o_busy, o_done, o_pass, o_fail, o_to, (o_cnt == 8'd0)};
                if (!hold) begin start0 = 1'b0; start1 = 1'b0; end
            end
            n_en   += int'(o_en);
            n_load += int'(o_load);
            n_mrn  += int'(!o_mrn);
            if ((o_pass && o_fail) || (!o_done && (o_pass || o_fail || o_to)) || (o_busy && o_done)
                || (o_cnt > 8'(p_n(s))))
                n_bad++;
            if (o_done) begin
                done_edge = k;
                break;
            end
            misr_ready = (k + 1 >= rdy_at);
        end
        start0 = 1'b0;
        start1 = 1'b0;
        misr_ready = 1'b0;
    endtask

    task automatic verify(input string tag, input bit s, input int exp_done, input bit ep, input bit ef,
                          input bit eto, input logic [15:0] ersig, input int done_edge, input int n_en,
                          input int n_load, input int n_mrn, input int n_bad, input logic [7:0] snap);
        chk({tag, "_done_edge"}, done_edge, exp_done);
        chk({tag, "_enable_cycles"}, n_en, p_n(s));
        chk({tag, "_load_cycles"}, n_load, 1);
        chk({tag, "_misr_rst_cycles"}, n_mrn, 1);
        chk({tag, "_invariants"}, n_bad, 0);
        chk({tag, "_seed_snapshot"}, snap, 8'b1010_0001);
        chk({tag, "_pass"}, o_pass, ep);
        chk({tag, "_fail"}, o_fail, ef);
        chk({tag, "_timeout"}, o_to, eto);
        chk({tag, "_result_sig"}, o_rsig, ersig);
        chk({tag, "_pattern_cnt"}, o_cnt, p_n(s));
    endtask

    initial begin
        vec_t        vecs[9];
        int          de, ne, nl, nm, nb;
        logic [7:0]  snap;
        logic [15:0] last_rsig[2];
        bit          found;

        vecs[0] = '{1'b0, 0,    16'h1234, 1'b0, 36, 1'b1, 1'b0, 1'b0, 16'h1234};
        vecs[1] = '{1'b0, 0,    16'hBEEF, 1'b0, 36, 1'b0, 1'b1, 1'b0, 16'hBEEF};
        vecs[2] = '{1'b0, 1000, 16'h0000, 1'b0, 98, 1'b0, 1'b1, 1'b1, 16'hBEEF};
        vecs[3] = '{1'b0, 50,   16'h1234, 1'b1, 51, 1'b1, 1'b0, 1'b0, 16'h1234};
        vecs[4] = '{1'b1, 0,    16'hA5A5, 1'b0, 6,  1'b1, 1'b0, 1'b0, 16'hA5A5};
        vecs[5] = '{1'b1, 100,  16'h0000, 1'b0, 9,  1'b0, 1'b1, 1'b1, 16'hA5A5};
        vecs[6] = '{1'b1, 9,    16'h0001, 1'b1, 10, 1'b0, 1'b1, 1'b0, 16'h0001};
        vecs[7] = '{1'b0, 98,   16'h1234, 1'b0, 99, 1'b1, 1'b0, 1'b0, 16'h1234};
        vecs[8] = '{1'b0, 99,   16'hBEEF, 1'b0, 98, 1'b0, 1'b1, 1'b1, 16'h1234};

        // Reset state.
        reset = 1'b1;
        repeat (3) tick();
        chk("rst_outputs0", {tpg_load0, tpg_enable0, misr_reset_n0, busy0, done0, pass0, fail0, timeout_err0}, 8'h00);
        chk("rst_outputs1", {tpg_load1, tpg_enable1, misr_reset_n1, busy1, done1, pass1, fail1, timeout_err1}, 8'h00);
        chk("rst_result_sig", result_sig0, 16'h0000);
        chk("rst_pattern_cnt", pattern_cnt0, 8'd0);
        reset = 1'b0;
        tick();
        chk("idle_outputs0", {tpg_load0, tpg_enable0, misr_reset_n0, busy0, done0}, 5'b00100);

        // Directed vectors.
        foreach (vecs[i]) begin
            do_run(vecs[i].s, vecs[i].rdy_at, vecs[i].sig, vecs[i].hold, de, ne, nl, nm, nb, snap);
            verify($sformatf("vec%0d", i), vecs[i].s, vecs[i].exp_done, vecs[i].exp_pass, vecs[i].exp_fail,
                   vecs[i].exp_to, vecs[i].exp_rsig, de, ne, nl, nm, nb, snap);
        end

        // Done holds its results while start stays low.
        sel = 1'b0;
        repeat (5) tick();
        chk("done_hold", {o_done, o_busy, o_fail, o_to}, 4'b1011);

        // Reset in the middle of a run.
        sel = 1'b0;
        start0 = 1'b1;
        found = 1'b0;
        for (int k = 0; k < 100; k++) begin
            tick();
            start0 = 1'b0;
            if (o_cnt == 8'd10 && o_en) begin found = 1'b1; break; end
        end
        chk("midrun_reached_cnt10", found, 1'b1);
        reset = 1'b1;
        tick();
        chk("midrun_rst_strobes", {tpg_enable0, tpg_load0, misr_reset_n0, busy0}, 4'b0000);
        chk("midrun_rst_flags", {done0, pass0, fail0, timeout_err0}, 4'b0000);
        chk("midrun_rst_cnt", pattern_cnt0, 8'd0);
        chk("midrun_rst_rsig", result_sig0, 16'h0000);
        reset = 1'b0;
        tick();
        chk("midrun_idle", {misr_reset_n0, busy0, done0, tpg_enable0}, 4'b1000);
        last_rsig[0] = 16'h0000;
        last_rsig[1] = 16'h0000;

        // Randomized runs against the timing/outcome model.
        for (int it = 0; it < 24; it++) begin
            bit          s, hold, eto, ep;
            int          w, r;
            logic [15:0] sig, ersig;
            s    = 1'($urandom_range(0, 1));
            hold = 1'($urandom_range(0, 1));
            w    = 1 + p_n(s) + ((p_lat(s) < 1) ? 1 : p_lat(s));
            r    = $urandom_range(0, w + p_to(s) + 3);
            sig  = ($urandom_range(0, 1) == 1) ? p_gold(s) : 16'($urandom);
            eto  = (r > w + p_to(s));
            ep   = !eto && (sig == p_gold(s));
            ersig = eto ? last_rsig[s] : sig;
            last_rsig[s] = ersig;
            do_run(s, r, sig, hold, de, ne, nl, nm, nb, snap);
            verify($sformatf("rnd%0d", it), s, model_done(s, r), ep, !ep, eto, ersig, de, ne, nl, nm, nb, snap);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
